// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect strobe,
// decode-side instruction stream and the sticky response-error flag.
interface instr_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic              rsp_err;

    // The fetch unit itself
    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, rsp_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               out_ready
    );

    // Memory, branch unit and decoder as seen from the fetch unit
    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, rsp_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches under a credit limit, matches
// in-order memory responses against an in-flight tag FIFO, and buffers accepted
// instructions in a small queue for the decoder. Redirects flush the queue and
// turn every in-flight tag stale so late responses are dropped.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                PC_INC   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    localparam int             PW       = $clog2(QDEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW:0]    QDEPTH_C = (CW+1)'(QDEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     qcount;
    logic [CW:0]       credit_used;
    logic              rsp_err;

    // In-flight tags. A live flag per entry plays the role of the epoch: a
    // redirect clears every flag at once, so a stale tag can never alias the
    // current epoch no matter how many redirects happen while it is in flight.
    logic [PW-1:0]     tag_wr;
    logic [PW-1:0]     tag_rd;
    logic [ADDR_W-1:0] tag_pc   [QDEPTH];
    logic [QDEPTH-1:0] tag_live;

    // Instruction queue
    logic [PW-1:0]     q_wr;
    logic [PW-1:0]     q_rd;
    logic [ADDR_W-1:0] q_pc     [QDEPTH];
    logic [DATA_W-1:0] q_instr  [QDEPTH];

    logic fire;
    logic pop;
    logic rsp_take;
    logic rsp_orphan;
    logic q_push;

    assign credit_used        = {1'b0, outstanding} + {1'b0, qcount};
    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (credit_used < QDEPTH_C);
    assign bus.imem_req_addr  = fetch_pc;
    assign fire               = bus.imem_req_valid && bus.imem_req_ready;

    assign bus.out_valid      = !reset && (qcount != '0) && !bus.redirect_valid;
    assign bus.out_pc         = q_pc[q_rd];
    assign bus.out_instr      = q_instr[q_rd];
    assign pop                = bus.out_valid && bus.out_ready;

    // A response with nothing outstanding is an error and touches no state.
    assign rsp_take           = bus.imem_rsp_valid && (outstanding != '0);
    assign rsp_orphan         = bus.imem_rsp_valid && (outstanding == '0);
    assign q_push             = rsp_take && tag_live[tag_rd] && !bus.redirect_valid;

    assign bus.rsp_err        = rsp_err;

    // Control state: PC, credit counters, FIFO pointers, live flags, error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            qcount      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            tag_live    <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
            end else if (fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            end

            outstanding <= outstanding + CW'(fire) - CW'(rsp_take);

            if (fire) begin
                tag_wr <= tag_wr + PW'(1);
            end
            if (rsp_take) begin
                tag_rd <= tag_rd + PW'(1);
            end

            if (bus.redirect_valid) begin
                tag_live <= '0;
            end else if (fire) begin
                tag_live[tag_wr] <= 1'b1;
            end

            if (bus.redirect_valid) begin
                qcount <= '0;
                q_rd   <= q_wr;
            end else begin
                if (q_push) begin
                    q_wr <= q_wr + PW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PW'(1);
                end
                qcount <= qcount + CW'(q_push) - CW'(pop);
            end

            if (rsp_orphan) begin
                rsp_err <= 1'b1;
            end
        end
    end

    // Payload storage for tags and queued instructions; no reset needed
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (q_push && !reset) begin
            q_pc[q_wr]    <= tag_pc[tag_rd];
            q_instr[q_wr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a directed vector table, then directed and
// randomized runs against a queue-based memory and fetch-stream model.
module tb_instr_fetch_unit;
    localparam int QDEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, rdy, rspv;
        logic [31:0] rspd;
        logic        redir;
        logic [31:0] rpc;
        logic        ordy;
        logic        e_reqv;
        logic [31:0] e_addr;
        logic        e_outv;
        logic [31:0] e_pc, e_instr;
        logic        e_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    function automatic vec_t mk(logic rst, logic rdy, logic rspv, logic [31:0] rspd,
                                logic redir, logic [31:0] rpc, logic ordy,
                                logic e_reqv, logic [31:0] e_addr, logic e_outv,
                                logic [31:0] e_pc, logic [31:0] e_instr, logic e_err);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.redir = redir;
        v.rpc = rpc; v.ordy = ordy; v.e_reqv = e_reqv; v.e_addr = e_addr;
        v.e_outv = e_outv; v.e_pc = e_pc; v.e_instr = e_instr; v.e_err = e_err;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] pc; bit stale; } tag_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    tag_t        m_inflight[$];
    logic [31:0] m_outq[$];
    mreq_t       mem_q[$];
    logic [31:0] popped[$];
    logic [31:0] fired[$];
    logic [31:0] m_fetch;
    logic [31:0] m_stream;
    bit          m_err;
    int          lat;
    bit          rand_ready, rand_oready, oready_val;

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
    endtask

    task automatic eng_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1; cyc++;
        end
        reset = 1'b0;
        m_inflight.delete(); m_outq.delete(); mem_q.delete();
        popped.delete(); fired.delete();
        m_fetch = 32'h0; m_stream = 32'h0; m_err = 1'b0;
    endtask

    task automatic eng_cycle(input bit redir, input logic [31:0] tgt);
        bit   exp_rv, exp_ov, fire, pop, rv;
        tag_t t;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        bus.imem_req_ready = rand_ready  ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.out_ready      = rand_oready ? 1'($urandom_range(0, 1)) : oready_val;
        rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rv ? mem_data(mem_q[0].addr) : 32'h0;
        @(negedge clk);
        exp_rv = !redir && ((m_inflight.size() + m_outq.size()) < QDEPTH);
        exp_ov = !redir && (m_outq.size() != 0);
        chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_fetch);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_pc", bus.out_pc, m_outq[0]);
            chk("out_instr", bus.out_instr, mem_data(m_outq[0]));
        end
        chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        fire = exp_rv && bus.imem_req_ready;
        pop  = exp_ov && bus.out_ready;
        if (pop) begin
            chk("seq_pc", bus.out_pc, m_stream);
            popped.push_back(bus.out_pc);
            m_stream = m_outq[0] + 32'd4;
            void'(m_outq.pop_front());
        end
        if (redir) begin
            foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
            m_outq.delete();
            m_fetch  = tgt;
            m_stream = tgt;
        end
        if (rv) begin
            void'(mem_q.pop_front());
            if (m_inflight.size() == 0) m_err = 1'b1;
            else begin
                t = m_inflight.pop_front();
                if (!t.stale && !redir) m_outq.push_back(t.pc);
            end
        end
        if (fire) begin
            m_inflight.push_back('{pc: m_fetch, stale: 1'b0});
            mem_q.push_back('{addr: m_fetch, due: cyc + lat});
            fired.push_back(m_fetch);
            m_fetch = m_fetch + 32'd4;
        end
        @(posedge clk); #1; cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) eng_cycle(1'b0, 32'h0);
    endtask

    task automatic chk_q(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
        if (idx < q.size()) chk(name, q[idx], exp);
        else chk(name, 32'hFFFF_FFFF, exp);
    endtask

    initial begin
        // rst rdy rspv rspd          redir rpc        ordy | reqv addr        outv pc         instr         err
        vt[0]  = mk(1, 1, 0, 32'h0,         0, 32'h0,    0,   0, 32'h0,      0, 32'h0,    32'h0,         0);
        vt[1]  = mk(1, 1, 0, 32'h0,         0, 32'h0,    0,   0, 32'h0,      0, 32'h0,    32'h0,         0);
        vt[2]  = mk(0, 1, 0, 32'h0,         0, 32'h0,    0,   1, 32'h0,      0, 32'h0,    32'h0,         0);
        vt[3]  = mk(0, 0, 1, 32'h1111_0000, 0, 32'h0,    0,   1, 32'h4,      0, 32'h0,    32'h0,         0);
        vt[4]  = mk(0, 1, 0, 32'h0,         0, 32'h0,    0,   1, 32'h4,      1, 32'h0,    32'h1111_0000, 0);
        vt[5]  = mk(0, 0, 1, 32'h2222_0004, 0, 32'h0,    1,   1, 32'h8,      1, 32'h0,    32'h1111_0000, 0);
        vt[6]  = mk(0, 0, 0, 32'h0,         0, 32'h0,    0,   1, 32'h8,      1, 32'h4,    32'h2222_0004, 0);
        vt[7]  = mk(0, 1, 0, 32'h0,         1, 32'h100,  1,   0, 32'h8,      0, 32'h0,    32'h0,         0);
        vt[8]  = mk(0, 1, 0, 32'h0,         0, 32'h0,    0,   1, 32'h100,    0, 32'h0,    32'h0,         0);
        vt[9]  = mk(0, 0, 1, 32'h3333_0100, 0, 32'h0,    1,   1, 32'h104,    0, 32'h0,    32'h0,         0);
        vt[10] = mk(0, 0, 0, 32'h0,         0, 32'h0,    1,   1, 32'h104,    1, 32'h100,  32'h3333_0100, 0);
        vt[11] = mk(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,    1,   1, 32'h104,    0, 32'h0,    32'h0,         0);
        vt[12] = mk(0, 0, 0, 32'h0,         0, 32'h0,    1,   1, 32'h104,    0, 32'h0,    32'h0,         1);
        vt[13] = mk(1, 1, 0, 32'h0,         0, 32'h0,    1,   0, 32'h104,    0, 32'h0,    32'h0,         1);
        vt[14] = mk(0, 0, 0, 32'h0,         0, 32'h0,    0,   1, 32'h0,      0, 32'h0,    32'h0,         0);

        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1; cyc++;

        for (int i = 0; i < NV; i++) begin
            reset              = vt[i].rst;
            bus.imem_req_ready = vt[i].rdy;
            bus.imem_rsp_valid = vt[i].rspv;
            bus.imem_rsp_data  = vt[i].rspd;
            bus.redirect_valid = vt[i].redir;
            bus.redirect_pc    = vt[i].rpc;
            bus.out_ready      = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vt[i].e_reqv));
            chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_outv));
            if (vt[i].e_outv) begin
                chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vt[i].e_pc);
                chk($sformatf("vec%0d_out_instr", i), bus.out_instr, vt[i].e_instr);
            end
            chk($sformatf("vec%0d_rsp_err", i), 32'(bus.rsp_err), 32'(vt[i].e_err));
            @(posedge clk); #1; cyc++;
        end

        // Sequential fetch, single-cycle memory, consumer always ready
        lat = 1; rand_ready = 0; rand_oready = 0; oready_val = 1;
        eng_reset();
        run(12);
        chk_q("seq_first_fire", fired, 0, 32'h0);
        chk_q("seq_pop0", popped, 0, 32'h0);
        chk_q("seq_pop1", popped, 1, 32'h4);

        // Stalled consumer: credit stops fetch at queue depth, then drains
        eng_reset();
        oready_val = 0;
        run(10);
        chk("stall_fire_count", 32'(fired.size()), 32'(QDEPTH));
        oready_val = 1;
        run(8);
        for (int i = 0; i < 4; i++) chk_q("stall_drain", popped, i, 32'(i * 4));
        chk_q("stall_resume_addr", fired, 4, 32'h10);

        // Redirect with two requests outstanding on a 3-cycle memory
        lat = 3;
        eng_reset();
        run(2);
        chk("redir_outstanding", 32'(fired.size()), 32'd2);
        eng_cycle(1'b1, 32'h100);
        run(15);
        chk_q("redir_pop0", popped, 0, 32'h100);
        chk_q("redir_pop1", popped, 1, 32'h104);

        // Address wrap at the top of the space
        lat = 1;
        eng_reset();
        eng_cycle(1'b1, 32'hFFFF_FFFC);
        run(10);
        chk_q("wrap_fire0", fired, 0, 32'hFFFF_FFFC);
        chk_q("wrap_fire1", fired, 1, 32'h0);
        chk_q("wrap_pop1", popped, 1, 32'h0);

        // Random ready on both sides, 3-cycle memory, then random redirects
        lat = 3; rand_ready = 1; rand_oready = 1;
        eng_reset();
        run(500);
        chk("rand_progress", 32'(popped.size() > 50), 32'd1);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) eng_cycle(1'b1, $urandom() & 32'hFFFF_FFFC);
            else eng_cycle(1'b0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter PC_INC, default 4, PC increment per fetch.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have parameter QDEPTH, default 4, instruction queue depth; power of two, >=2.
REQ-006 SHALL have clk, input, 1, clock; all state updates on rising edge.
REQ-007 SHALL have reset, input, 1; reset is synchronous, active-high, on clock clk.
REQ-008 SHALL have imem_req_valid, output, 1, fetch request valid.
REQ-009 SHALL have imem_req_ready, input, 1, memory accepts request.
REQ-010 SHALL have imem_req_addr, output, ADDR_W, fetch address (= fetch_pc).
REQ-011 SHALL have imem_rsp_valid, input, 1, response data valid; in order, never back-pressured.
REQ-012 SHALL have imem_rsp_data, input, DATA_W, fetched instruction.
REQ-013 SHALL have redirect_valid, input, 1, branch/jump redirect strobe.
REQ-014 SHALL have redirect_pc, input, ADDR_W, redirect target, used unmodified.
REQ-015 SHALL have out_valid, output, 1, instruction available at queue head.
REQ-016 SHALL have out_ready, input, 1, consumer accepts instruction.
REQ-017 SHALL have out_pc, output, ADDR_W, PC of head instruction.
REQ-018 SHALL have out_instr, output, DATA_W, head instruction.
REQ-019 SHALL have rsp_err, output, 1, sticky: response arrived with zero requests outstanding.

Function
REQ-020 SHALL hold fetch_pc register; request fires when imem_req_valid && imem_req_ready; on fire fetch_pc += PC_INC, modulo 2^ADDR_W (wraps, no flag).
REQ-021 SHALL track outstanding (issued, unanswered requests) and qcount (queue occupancy); imem_req_valid = !redirect_valid && (outstanding + qcount < QDEPTH).
REQ-022 SHALL push {fetch_pc, epoch} into an in-flight tag FIFO (depth QDEPTH) on each fire.
REQ-023 SHALL, on imem_rsp_valid, pop in-flight tag; tag epoch == current epoch -> write {tag pc, imem_rsp_data} into queue; mismatch -> discard.
REQ-024 SHALL register queue writes: response visible on out_* the cycle after imem_rsp_valid; no combinational bypass.
REQ-025 SHALL drive out_valid = (qcount != 0) && !redirect_valid; pop head when out_valid && out_ready.
REQ-026 SHALL allow simultaneous push and pop; qcount unchanged; credit rule (REQ-021) guarantees no overflow.
REQ-027 SHALL, on redirect_valid: fetch_pc <= redirect_pc, epoch toggles, queue flushed (qcount <= 0), outstanding unchanged; no fire and no pop that cycle.
REQ-028 SHALL, if a response arrives in a redirect cycle, discard it (pre-redirect epoch) while still decrementing outstanding.
REQ-029 SHALL let back-to-back redirects take the last target; epoch toggles each time; stale responses remain discarded (in-flight tag FIFO holds <= QDEPTH, so 1-bit epoch wraps only after all stale tags drain -- implementation SHALL keep per-tag epoch compare valid by blocking fires while any tag of the previous-previous epoch remains; 2-bit epoch acceptable).
REQ-030 SHALL, on imem_rsp_valid with outstanding == 0, ignore the data, set rsp_err, leave counters unchanged.
REQ-031 SHALL keep imem_req_addr stable while imem_req_valid && !imem_req_ready, except on redirect.

Reset
REQ-032 SHALL on reset set fetch_pc=RESET_PC, outstanding=0, qcount=0, epoch=0, rsp_err=0, tag FIFO empty; reset overrides redirect and responses same cycle.
REQ-033 SHALL hold imem_req_valid=0 and out_valid=0 during reset cycles; first request at RESET_PC in cycle after reset deasserts.
REQ-034 SHALL drop responses to requests issued before a mid-operation reset (counted as rsp_err if none outstanding).

Verification
REQ-035 Reset, ready=1, 1-cycle memory, out_ready=1 -> addresses 0,4,8,12...; out_pc 0 with out_instr matching, two cycles after first fire.
REQ-036 out_ready=0, QDEPTH=4 -> exactly 4 fires, then imem_req_valid=0; release out_ready -> drains 0,4,8,12, fetch resumes at 16.
REQ-037 Redirect to 0x100 with 2 outstanding -> those 2 responses discarded; next out_pc=0x100, then 0x104.
REQ-038 fetch_pc=0xFFFFFFFC, ADDR_W=32 -> next address 0x00000000, no error.
REQ-039 imem_rsp_valid with nothing outstanding -> rsp_err=1 sticky, queue unchanged; reset clears rsp_err.
REQ-040 imem_req_ready toggled randomly, 3-cycle memory latency -> out_pc strictly sequential, no loss or duplication.
